// File: rtl/hello_cnt_sched.sv
// hello_cnt_sched: round-robin time-sharing of the hello down-counter between NREQ requesters.
// Define HELLO_CNT_SCHED_ASSERT_EN to compile in embedded immediate assertions.
module hello_cnt_sched #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 11
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*CNT_W-1:0]   len,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic [CNT_W-1:0]        cnt
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] rr_ptr, rr_n, own, own_n, win, idx;
  logic found;
  logic [NREQ-1:0] gnt_n;
  logic [CNT_W-1:0] cnt_n, len_w;
  // Search starts just past the last owner so contenders alternate.
  always_comb begin
    found = 1'b0;
    win = rr_ptr;
    idx = rr_ptr;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IW'((int'(rr_ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win = idx;
      end
    end
  end
  assign len_w = len[win*CNT_W +: CNT_W];
  assign done  = (state == DONE) ? gnt : '0;
  assign busy  = (state != IDLE);
  always_comb begin
    state_n = state;
    gnt_n = gnt;
    cnt_n = cnt;
    rr_n = rr_ptr;
    own_n = own;
    case (state)
      IDLE: if (found) begin
        gnt_n = NREQ'(1) << win;
        cnt_n = len_w;
        own_n = win;
        state_n = (len_w != '0) ? RUN : DONE;
      end
      RUN: if (!req[own]) begin
        state_n = IDLE;
        gnt_n = '0;
        rr_n = own;
      end else begin
        cnt_n = cnt - CNT_W'(1);
        state_n = (cnt == CNT_W'(1)) ? DONE : RUN;
      end
      DONE: begin
        state_n = IDLE;
        gnt_n = '0;
        rr_n = own;
      end
      default: begin
        state_n = IDLE;
        gnt_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      gnt <= '0;
      cnt <= '0;
      rr_ptr <= IW'(NREQ - 1);
      own <= '0;
    end else begin
      state <= state_n;
      gnt <= gnt_n;
      cnt <= cnt_n;
      rr_ptr <= rr_n;
      own <= own_n;
    end
  end
`ifdef HELLO_CNT_SCHED_ASSERT_EN
  logic [CNT_W-1:0] len_q;
  logic done_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      len_q <= '0;
      done_q <= 1'b0;
    end else begin
      if (state == IDLE && found) len_q <= len_w;
      done_q <= |done;
      assert ($onehot0(gnt)) else $error("gnt not one-hot0: %b", gnt);
      assert ((done & ~gnt) == '0) else $error("done %b outside gnt %b", done, gnt);
      assert (!(done_q && |done)) else $error("done high two cycles");
      assert (cnt <= len_q) else $error("cnt %0d exceeds len %0d", cnt, len_q);
      assert (busy == (gnt != '0)) else $error("busy/gnt disagree");
      assert (state == IDLE || state == RUN || state == DONE) else $error("illegal state");
    end
  end
`endif
endmodule

// File: doc/hello_cnt_sched.md
Name: hello_cnt_sched

Overview:
- Time-shares the single 11-bit down-counter resource of the hello block between NREQ requesters.
- Each requester asks for a countdown of programmable length. The scheduler grants round-robin, loads and runs the counter, and pulses per-requester done on expiry.
- Sits between requesting agents and the counter. It is the only block that loads or decrements the counter.

Parameters:
- NREQ, 4, number of requesters (2..8)
- CNT_W, 11, counter width; matches the hello counter

Ports:
- clk  input  1  single clock; all logic on posedge
- rst  input  1  synchronous, active-low reset; sampled on posedge clk; rst==0 resets
- req  input  NREQ  level request per requester; held until done or abandoned
- len  input  NREQ*CNT_W  countdown length per requester; slice i = len[i*CNT_W +: CNT_W]; sampled only at grant
- gnt  output  NREQ  one-hot0 grant; owner of the counter
- done  output  NREQ  one-cycle completion pulse to the owner
- busy  output  1  high when state != IDLE
- cnt  output  CNT_W  current counter value

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, gnt=0, done=0, busy=0, cnt=0, rr_ptr=NREQ-1, so requester 0 wins first. Reset overrides everything, including mid-RUN.
- States: IDLE, RUN, DONE. All outputs are registered or decoded from registered state.
- IDLE, no req: hold; cnt holds its last value.
- IDLE, any req:
  - Winner w = first i with req[i], searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Next edge: gnt<=onehot(w), cnt<=len_w.
  - State <= RUN if len_w!=0, else DONE.
- RUN, req[w]==1:
  - cnt<=cnt-1 every edge.
  - When cnt==1 at the edge: cnt<=0, state<=DONE.
- RUN, req[w]==0 (abandon): next edge state<=IDLE, gnt<=0, rr_ptr<=w, cnt held, no done pulse.
- DONE:
  - done[w]=1 for exactly this one cycle; gnt[w] stays 1.
  - Next edge: state<=IDLE, gnt<=0, rr_ptr<=w.
- Latency for len=L>=1: gnt high L+1 cycles, with done on the last of them. For L=0: gnt high 1 cycle, done in that same cycle.
- Minimum of one IDLE cycle between consecutive grants. busy is low for that cycle.
- Requests arriving while busy wait; they are never lost while held.
- len changes after the grant have no effect. req changes of non-owners while busy have no effect.
- Simultaneous requests are resolved only by the round-robin order. Two contenders alternate strictly.
- Arithmetic: cnt is unsigned CNT_W. Max len = 2^CNT_W-1 (2047) runs 2047 RUN cycles. No wrap, since decrement stops at 0.
- req[w] dropping in the same cycle cnt==1 counts as an abandon: no done.

Optional Feature:
- Macro: HELLO_CNT_SCHED_ASSERT_EN.
- Defined: the block compiles in embedded immediate assertions, checked on posedge when rst==1:
  - gnt is one-hot0
  - done is a subset of gnt
  - done is never high for two consecutive cycles
  - cnt never exceeds the len latched at grant
  - busy == (gnt!=0)
  - state is always a legal encoding
- Defined: assertion failures report via $error.
- Undefined: no assertion code and no extra state. Functional behaviour is identical either way.

Test Plan:
- Reset then req=4'b0001, len0=3 -> grant edge: gnt=0001, cnt=3. Then cnt 2,1,0; done[0] high one cycle with cnt=0; gnt=0 the cycle after; gnt high 4 cycles total.
- req=4'b1111, all len=1, held -> grants 0,1,2,3,0 in order, each separated by one IDLE cycle; done follows each grant by one cycle.
- req=4'b0100, len2=0 -> gnt=0100 and done[2]=1 in the same single cycle; busy high 1 cycle.
- req0 with len0=10, drop req0 after 4 RUN cycles -> next edge gnt=0, no done pulse, cnt frozen at 6. Then req1 is granted ahead of req0 if both request.
- rst=0 asserted mid-RUN with cnt=5 -> next edge gnt=0, done=0, cnt=0, busy=0. After release, req=4'b1001 grants requester 0 first.
- len0=2047 -> exactly 2047 decrements, done[0] at cnt=0, no wrap to 2047.
